chess_clock_ctrl: RTL and testbench
===================================

# chess_clock_ctrl

Two-player chess clock controller that sequences the single countdown timebase between White and Black. It owns both players' remaining-time registers and runs exactly one player's clock at a time. It switches sides on each completed move and applies a Fischer increment to the player who moved. It supports pause and declares a flag fall, driving the on-screen clock digits and the game-over logic of the chess game.

## Interface

Parameters:
- TICK_DIV, 60: `clk` cycles per clock second (frame ticks per second); must be ≥ 2.
- START_SECONDS, 180: initial time per player; range 1..255.
- INC_SECONDS, 2: Fischer increment added to the mover's time on each accepted move; range 0..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- game_start  in  1  one-cycle pulse; reloads both clocks and starts White's clock.
- move_done  in  1  one-cycle pulse from move logic; the active side has completed a legal move.
- pause  in  1  level; while high, no clock runs.
- white_min  out  3  White remaining minutes (`white_time / 60`).
- white_sec  out  6  White remaining seconds (`white_time % 60`).
- black_min  out  3  Black remaining minutes.
- black_sec  out  6  Black remaining seconds.
- active_side  out  1  0 = White to move, 1 = Black to move.
- running  out  1  high in RUN_W or RUN_B.
- move_ack  out  1  one-cycle pulse, asserted the cycle after an accepted move_done.
- flag_white  out  1  White's time reached 0; sticky until game_start or reset.
- flag_black  out  1  Black's time reached 0; sticky until game_start or reset.
- game_over  out  1  high in OVER.

## Operation

- State registers: white_time[7:0], black_time[7:0], prescaler cnt over 0..TICK_DIV-1, FSM, saved_side.
- FSM states: IDLE, RUN_W, RUN_B, PAUSED, OVER.
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - white_time = black_time = START_SECONDS; cnt = 0; saved_side = 0.
  - active_side = 0; running = 0; move_ack = 0; both flags = 0; game_over = 0.
- game_start has the highest priority and is accepted in any state.
  - Reloads both times to START_SECONDS.
  - Sets cnt = 0 and clears both flags.
  - Next state is RUN_W.
- RUN_W / RUN_B:
  - cnt increments each cycle.
  - At cnt == TICK_DIV-1 (a "tick"), cnt wraps to 0 and the active player's time decrements by 1.
  - If that decrement produces 0, the side's flag sets and the next state is OVER.
- move_done in RUN_x, no tick in the same cycle:
  - mover_time = min(mover_time + INC_SECONDS, 255), computed 9-bit then saturated.
  - cnt = 0; switch to the other RUN state; move_ack pulses next cycle.
- move_done and tick in the same cycle:
  - Decrement first.
  - If the result is 0, the flag wins: the move is rejected, no move_ack, next state OVER.
  - Otherwise the result is min(t - 1 + INC_SECONDS, 255), sides switch, and move_ack pulses.
- pause = 1 in RUN_x (game_start absent):
  - saved_side = active side; go to PAUSED; cnt holds.
  - A tick or move_done in that same cycle is ignored.
- PAUSED:
  - Times and cnt are frozen.
  - When pause = 0, return to RUN_W or RUN_B per saved_side, resuming cnt from its held value.
- move_done is ignored in IDLE, PAUSED and OVER. pause has no effect in IDLE and OVER.
- OVER: all times frozen; only game_start or reset leaves this state.
- active_side:
  - 0 in RUN_W, 1 in RUN_B.
  - Equals saved_side in PAUSED.
  - Holds the side whose flag fell in OVER.
  - 0 in IDLE.
- min/sec outputs are combinational from the time registers; a maximum of 255 gives min 4, sec 15.

## Timing

- Time registers update on the rising edge that samples the tick or move. min/sec reflect the new value the same cycle the register changes.
- First decrement after entering RUN_x with cnt = 0 occurs exactly TICK_DIV cycles later.
- move_ack is registered: high for one cycle, one cycle after the accepted move_done.
- flag_x and game_over assert on the edge that writes 0 to the time register.
- Reset deassertion is synchronous to clk (external synchronizer). Assertion mid-run clears all state immediately, with no wait for an edge.
- Back-to-back move_done on consecutive cycles: each pulse is evaluated against the then-current side. This is legal and alternates sides each cycle.

## Test plan

Benches use TICK_DIV = 4, START_SECONDS = 3, INC_SECONDS = 2 unless stated.

- Reset then game_start -> state RUN_W, white 0:03, black 0:03; white 0:02 after 4 cycles, 0:01 after 8; black stays 0:03; running = 1.
- White runs down with no move -> at cycle 12 white_time = 0, flag_white = 1, game_over = 1, active_side = 0; a further move_done gives no move_ack.
- move_done at white 0:02, no tick -> white 0:04, active_side = 1, move_ack one cycle later; black decrements to 0:02 after 4 cycles.
- move_done coincident with a tick at white_time = 1 -> flag_white = 1, no side switch, no move_ack. Coincident at white_time = 2 -> white = 3, side switches.
- pause high for 10 cycles mid-turn with cnt = 2 -> times frozen, active_side held. After release, the next decrement occurs 2 cycles later. move_done during pause is ignored.
- START_SECONDS = 254, INC_SECONDS = 5, immediate moves -> White saturates at 255 (min 4, sec 15). Asserting reset low mid-run -> IDLE, both times 254, all flags 0.

Source files
------------

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock controller.
// Holds both players' remaining seconds, runs one side's countdown at a time,
// applies a saturating Fischer increment on each accepted move, supports
// pause/resume and declares flag fall.
module chess_clock_ctrl #(
  parameter int TICK_DIV      = 60,
  parameter int START_SECONDS = 180,
  parameter int INC_SECONDS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_start,
  input  logic       move_done,
  input  logic       pause,
  output logic [2:0] white_min,
  output logic [5:0] white_sec,
  output logic [2:0] black_min,
  output logic [5:0] black_sec,
  output logic       active_side,
  output logic       running,
  output logic       move_ack,
  output logic       flag_white,
  output logic       flag_black,
  output logic       game_over
);

  localparam int            CW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [7:0]    START_T = 8'(START_SECONDS);
  localparam logic [8:0]    INC_T   = 9'(INC_SECONDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_W  = 3'd1,
    RUN_B  = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_whiteTime;
  logic [7:0]    r_blackTime;
  logic [CW-1:0] r_cnt;
  logic          r_savedSide;

  logic          w_side;
  logic          w_tick;
  logic [7:0]    w_curTime;
  logic [7:0]    w_dec;
  logic          w_decZero;
  logic [8:0]    w_sum9;
  logic [7:0]    w_incTime;

  // Active side's time, its decremented value and the saturated post-move value
  always_comb begin
    w_side    = (r_state == RUN_B);
    w_tick    = (r_cnt == CNT_MAX);
    w_curTime = w_side ? r_blackTime : r_whiteTime;
    w_dec     = w_curTime - 8'd1;
    w_decZero = (w_dec == 8'd0);
    w_sum9    = {1'b0, (w_tick ? w_dec : w_curTime)} + INC_T;
    w_incTime = w_sum9[8] ? 8'hFF : w_sum9[7:0];
  end

  assign white_min = 3'(r_whiteTime / 8'd60);
  assign white_sec = 6'(r_whiteTime % 8'd60);
  assign black_min = 3'(r_blackTime / 8'd60);
  assign black_sec = 6'(r_blackTime % 8'd60);

  // Game sequencing: start/reload, countdown ticks, moves, pause and flag fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_whiteTime <= START_T;
      r_blackTime <= START_T;
      r_cnt       <= '0;
      r_savedSide <= 1'b0;
      active_side <= 1'b0;
      running     <= 1'b0;
      move_ack    <= 1'b0;
      flag_white  <= 1'b0;
      flag_black  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      if (game_start) begin
        r_state     <= RUN_W;
        r_whiteTime <= START_T;
        r_blackTime <= START_T;
        r_cnt       <= '0;
        active_side <= 1'b0;
        running     <= 1'b1;
        flag_white  <= 1'b0;
        flag_black  <= 1'b0;
        game_over   <= 1'b0;
      end else begin
        case (r_state)
          RUN_W, RUN_B: begin
            if (pause) begin
              r_savedSide <= w_side;
              r_state     <= PAUSED;
              running     <= 1'b0;
            end else if (w_tick) begin
              r_cnt <= '0;
              if (w_decZero) begin
                if (w_side) begin
                  r_blackTime <= 8'd0;
                  flag_black  <= 1'b1;
                end else begin
                  r_whiteTime <= 8'd0;
                  flag_white  <= 1'b1;
                end
                r_state   <= OVER;
                running   <= 1'b0;
                game_over <= 1'b1;
              end else if (move_done) begin
                if (w_side) r_blackTime <= w_incTime;
                else        r_whiteTime <= w_incTime;
                r_state     <= w_side ? RUN_W : RUN_B;
                active_side <= ~w_side;
                move_ack    <= 1'b1;
              end else begin
                if (w_side) r_blackTime <= w_dec;
                else        r_whiteTime <= w_dec;
              end
            end else if (move_done) begin
              if (w_side) r_blackTime <= w_incTime;
              else        r_whiteTime <= w_incTime;
              r_cnt       <= '0;
              r_state     <= w_side ? RUN_W : RUN_B;
              active_side <= ~w_side;
              move_ack    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          PAUSED: begin
            if (!pause) begin
              r_state     <= r_savedSide ? RUN_B : RUN_W;
              active_side <= r_savedSide;
              running     <= 1'b1;
            end
          end
          IDLE, OVER: begin
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl.
// Two instances share one stimulus stream: a small-time clock (4/3/2) and a
// near-saturation clock (4/254/5). A seconds-based game model predicts every
// output each cycle; directed literal checks pin key moments of the game.
module tb_chess_clock_ctrl;

  localparam int TICK        = 4;
  localparam int MODE_IDLE   = 0;
  localparam int MODE_RUN    = 1;
  localparam int MODE_PAUSED = 2;
  localparam int MODE_OVER   = 3;

  typedef struct packed {
    int remW;
    int remB;
    int side;
    int mode;
    int frac;
    bit ack;
    bit flagW;
    bit flagB;
  } model_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic gameStart = 1'b0;
  logic moveDone = 1'b0;
  logic pauseIn = 1'b0;
  logic checkEn = 1'b0;

  logic [2:0] whiteMin [2];
  logic [5:0] whiteSec [2];
  logic [2:0] blackMin [2];
  logic [5:0] blackSec [2];
  logic       activeSide [2];
  logic       runningOut [2];
  logic       moveAck [2];
  logic       flagWhite [2];
  logic       flagBlack [2];
  logic       gameOver [2];

  model_t mdl [2];
  int checks = 0;
  int failures = 0;

  // Free-running clock
  always #5 clk = ~clk;

  chess_clock_ctrl #(.TICK_DIV(4), .START_SECONDS(3), .INC_SECONDS(2)) dutA (
    .clk(clk), .reset(resetN), .game_start(gameStart), .move_done(moveDone), .pause(pauseIn),
    .white_min(whiteMin[0]), .white_sec(whiteSec[0]), .black_min(blackMin[0]), .black_sec(blackSec[0]),
    .active_side(activeSide[0]), .running(runningOut[0]), .move_ack(moveAck[0]),
    .flag_white(flagWhite[0]), .flag_black(flagBlack[0]), .game_over(gameOver[0])
  );

  chess_clock_ctrl #(.TICK_DIV(4), .START_SECONDS(254), .INC_SECONDS(5)) dutB (
    .clk(clk), .reset(resetN), .game_start(gameStart), .move_done(moveDone), .pause(pauseIn),
    .white_min(whiteMin[1]), .white_sec(whiteSec[1]), .black_min(blackMin[1]), .black_sec(blackSec[1]),
    .active_side(activeSide[1]), .running(runningOut[1]), .move_ack(moveAck[1]),
    .flag_white(flagWhite[1]), .flag_black(flagBlack[1]), .game_over(gameOver[1])
  );

  function automatic int startOf(input int k);
    return (k == 0) ? 3 : 254;
  endfunction

  function automatic int incOf(input int k);
    return (k == 0) ? 2 : 5;
  endfunction

  function automatic model_t resetModel(input int k);
    model_t m;
    m.remW  = startOf(k);
    m.remB  = startOf(k);
    m.side  = 0;
    m.mode  = MODE_IDLE;
    m.frac  = 0;
    m.ack   = 1'b0;
    m.flagW = 1'b0;
    m.flagB = 1'b0;
    return m;
  endfunction

  // One clock's worth of game rules in terms of seconds remaining and
  // cycles elapsed within the current second
  function automatic model_t stepModel(input model_t m, input int k, input bit gs, input bit md, input bit pz);
    model_t n;
    int t;
    n = m;
    n.ack = 1'b0;
    if (gs) begin
      n = resetModel(k);
      n.mode = MODE_RUN;
    end else if (m.mode == MODE_RUN) begin
      if (pz) begin
        n.mode = MODE_PAUSED;
      end else begin
        t = (m.side == 1) ? m.remB : m.remW;
        n.frac = m.frac + 1;
        if (n.frac == TICK) begin
          n.frac = 0;
          t = t - 1;
          if (t == 0) begin
            n.mode = MODE_OVER;
            if (m.side == 1) n.flagB = 1'b1;
            else             n.flagW = 1'b1;
          end
        end
        if (n.mode == MODE_RUN && md) begin
          t = t + incOf(k);
          if (t > 255) t = 255;
          n.frac = 0;
          n.side = 1 - m.side;
          n.ack  = 1'b1;
        end
        if (m.side == 1) n.remB = t;
        else             n.remW = t;
      end
    end else if (m.mode == MODE_PAUSED && !pz) begin
      n.mode = MODE_RUN;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input int k, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s inst=%0d actual=%0d expected=%0d at %0t", name, k, actual, expected, $time);
    end
  endtask

  // Drive one input pattern for n cycles; pulses are dropped afterwards
  task automatic applyStimulus(input bit gs, input bit md, input bit pz, input int n);
    for (int i = 0; i < n; i++) begin
      gameStart = gs;
      moveDone  = md;
      pauseIn   = pz;
      @(posedge clk);
      #1;
    end
    gameStart = 1'b0;
    moveDone  = 1'b0;
  endtask

  // Model advances with the DUT on each edge and clears on async reset
  always @(posedge clk or negedge resetN) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetN) mdl[k] <= resetModel(k);
      else         mdl[k] <= stepModel(mdl[k], k, gameStart, moveDone, pauseIn);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("white_min", k, int'(whiteMin[k]), mdl[k].remW / 60);
        checkOutput("white_sec", k, int'(whiteSec[k]), mdl[k].remW % 60);
        checkOutput("black_min", k, int'(blackMin[k]), mdl[k].remB / 60);
        checkOutput("black_sec", k, int'(blackSec[k]), mdl[k].remB % 60);
        checkOutput("active_side", k, int'(activeSide[k]), mdl[k].side);
        checkOutput("running", k, int'(runningOut[k]), int'(mdl[k].mode == MODE_RUN));
        checkOutput("move_ack", k, int'(moveAck[k]), int'(mdl[k].ack));
        checkOutput("flag_white", k, int'(flagWhite[k]), int'(mdl[k].flagW));
        checkOutput("flag_black", k, int'(flagBlack[k]), int'(mdl[k].flagB));
        checkOutput("game_over", k, int'(gameOver[k]), int'(mdl[k].mode == MODE_OVER));
      end
    end
  end

  // Directed game scenarios with hand-computed expectations
  initial begin
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 2);
    checkOutput("rst_white_sec", 0, int'(whiteSec[0]), 3);
    checkOutput("rst_running", 0, int'(runningOut[0]), 0);
    checkOutput("rst_active", 0, int'(activeSide[0]), 0);
    checkOutput("rst_white_min", 1, int'(whiteMin[1]), 4);
    checkOutput("rst_white_sec", 1, int'(whiteSec[1]), 14);
    resetN  = 1'b1;
    checkEn = 1'b1;

    // White runs down with no move
    applyStimulus(1, 0, 0, 1);
    checkOutput("start_running", 0, int'(runningOut[0]), 1);
    checkOutput("start_white_sec", 0, int'(whiteSec[0]), 3);
    checkOutput("start_black_sec", 0, int'(blackSec[0]), 3);
    applyStimulus(0, 0, 0, 4);
    checkOutput("t4_white_sec", 0, int'(whiteSec[0]), 2);
    checkOutput("t4_black_sec", 0, int'(blackSec[0]), 3);
    checkOutput("t4_model_white", 0, mdl[0].remW, 2);
    applyStimulus(0, 0, 0, 4);
    checkOutput("t8_white_sec", 0, int'(whiteSec[0]), 1);
    applyStimulus(0, 0, 0, 4);
    checkOutput("t12_white_sec", 0, int'(whiteSec[0]), 0);
    checkOutput("t12_flag_white", 0, int'(flagWhite[0]), 1);
    checkOutput("t12_game_over", 0, int'(gameOver[0]), 1);
    checkOutput("t12_active", 0, int'(activeSide[0]), 0);
    checkOutput("t12_model_flag", 0, int'(mdl[0].flagW), 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("over_move_ack", 0, int'(moveAck[0]), 0);
    checkOutput("over_game_over", 0, int'(gameOver[0]), 1);

    // Plain move at white 0:02
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 4);
    checkOutput("mv_pre_white", 0, int'(whiteSec[0]), 2);
    applyStimulus(0, 1, 0, 1);
    checkOutput("mv_white_sec", 0, int'(whiteSec[0]), 4);
    checkOutput("mv_active", 0, int'(activeSide[0]), 1);
    checkOutput("mv_ack", 0, int'(moveAck[0]), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("mv_ack_drop", 0, int'(moveAck[0]), 0);
    applyStimulus(0, 0, 0, 3);
    checkOutput("mv_black_sec", 0, int'(blackSec[0]), 2);
    checkOutput("mv_white_hold", 0, int'(whiteSec[0]), 4);

    // Move coincident with the tick that takes white to 0
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 11);
    checkOutput("co1_pre_white", 0, int'(whiteSec[0]), 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("co1_flag", 0, int'(flagWhite[0]), 1);
    checkOutput("co1_ack", 0, int'(moveAck[0]), 0);
    checkOutput("co1_active", 0, int'(activeSide[0]), 0);
    checkOutput("co1_over", 0, int'(gameOver[0]), 1);

    // Move coincident with the tick at white 0:02
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 7);
    checkOutput("co2_pre_white", 0, int'(whiteSec[0]), 2);
    applyStimulus(0, 1, 0, 1);
    checkOutput("co2_white_sec", 0, int'(whiteSec[0]), 3);
    checkOutput("co2_active", 0, int'(activeSide[0]), 1);
    checkOutput("co2_ack", 0, int'(moveAck[0]), 1);

    // Pause mid-turn with two cycles of the second elapsed
    applyStimulus(0, 0, 0, 2);
    applyStimulus(0, 1, 1, 1);
    checkOutput("pz_ack", 0, int'(moveAck[0]), 0);
    checkOutput("pz_running", 0, int'(runningOut[0]), 0);
    applyStimulus(0, 0, 1, 9);
    checkOutput("pz_black_sec", 0, int'(blackSec[0]), 3);
    checkOutput("pz_active", 0, int'(activeSide[0]), 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rs_running", 0, int'(runningOut[0]), 1);
    checkOutput("rs_black_sec", 0, int'(blackSec[0]), 3);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rs1_black_sec", 0, int'(blackSec[0]), 3);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rs2_black_sec", 0, int'(blackSec[0]), 2);

    // Immediate moves: saturation on the 254/5 clock
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("sat_white_min", 1, int'(whiteMin[1]), 4);
    checkOutput("sat_white_sec", 1, int'(whiteSec[1]), 15);
    checkOutput("sat_active", 1, int'(activeSide[1]), 1);
    checkOutput("sat_a_white_sec", 0, int'(whiteSec[0]), 5);
    applyStimulus(0, 1, 0, 1);
    checkOutput("sat_black_min", 1, int'(blackMin[1]), 4);
    checkOutput("sat_black_sec", 1, int'(blackSec[1]), 15);
    checkOutput("sat_a_black_sec", 0, int'(blackSec[0]), 5);
    applyStimulus(0, 1, 0, 1);
    checkOutput("sat_hold_white", 1, int'(whiteSec[1]), 15);

    // Asynchronous reset in the middle of a running game
    resetN = 1'b0;
    #1;
    checkOutput("ar_white_min", 1, int'(whiteMin[1]), 4);
    checkOutput("ar_white_sec", 1, int'(whiteSec[1]), 14);
    checkOutput("ar_black_sec", 1, int'(blackSec[1]), 14);
    checkOutput("ar_running", 1, int'(runningOut[1]), 0);
    checkOutput("ar_active", 1, int'(activeSide[1]), 0);
    checkOutput("ar_flag_white", 1, int'(flagWhite[1]), 0);
    checkOutput("ar_flag_black", 1, int'(flagBlack[1]), 0);
    checkOutput("ar_a_white_sec", 0, int'(whiteSec[0]), 3);
    applyStimulus(0, 0, 0, 2);
    resetN = 1'b1;
    applyStimulus(0, 0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
